// File: rtl/csr_trap_ctrl_pkg.sv
// csr_trap_ctrl_pkg: cause codes, FSM states and tval selectors for the M-mode trap sequencer.
package csr_trap_ctrl_pkg;
    localparam int DEF_XLEN = 32;
    localparam int CAUSE_W  = 5;
    localparam logic [CAUSE_W-1:0] CAUSE_INST_MISALIGN = 5'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL       = 5'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT    = 5'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M       = 5'd11;
    localparam logic [CAUSE_W-1:0] CAUSE_LD_MISALIGN   = 5'd4;
    localparam logic [CAUSE_W-1:0] CAUSE_ST_MISALIGN   = 5'd6;
    localparam logic [CAUSE_W-1:0] CAUSE_MSI           = 5'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_MTI           = 5'd7;
    localparam logic [CAUSE_W-1:0] CAUSE_MEI           = 5'd11;
    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_COMMIT, S_REDIRECT} state_e;
    typedef enum logic [1:0] {TV_ZERO, TV_INST, TV_ADDR} tval_sel_e;
endpackage

// File: rtl/csr_trap_ctrl_if.sv
// csr_trap_ctrl_if: pipeline/CSR-side signals of the trap sequencer.
interface csr_trap_ctrl_if #(parameter int XLEN = csr_trap_ctrl_pkg::DEF_XLEN);
    logic            i_valid;
    logic [XLEN-1:0] i_PC;
    logic [31:0]     i_inst;
    logic [XLEN-1:0] i_badaddr;
    logic            i_ex_inst_addr, i_ex_illegal, i_ex_ebreak, i_ex_ecall, i_ex_ld_addr, i_ex_st_addr;
    logic            i_mret;
    logic            i_msip, i_mtip, i_meip;
    logic            i_mstatus_mie;
    logic [2:0]      i_mie;
    logic [XLEN-1:0] i_mtvec, i_mepc;
    logic            i_mem_busy;
    logic            o_stall, o_flush, o_trap_we, o_mret_restore, o_redirect, o_drain_err;
    logic [XLEN-1:0] o_epc, o_cause, o_tval, o_target;
    modport master (
        output i_valid, i_PC, i_inst, i_badaddr, i_ex_inst_addr, i_ex_illegal, i_ex_ebreak,
               i_ex_ecall, i_ex_ld_addr, i_ex_st_addr, i_mret, i_msip, i_mtip, i_meip,
               i_mstatus_mie, i_mie, i_mtvec, i_mepc, i_mem_busy,
        input  o_stall, o_flush, o_trap_we, o_mret_restore, o_redirect, o_drain_err,
               o_epc, o_cause, o_tval, o_target
    );
    modport slave (
        input  i_valid, i_PC, i_inst, i_badaddr, i_ex_inst_addr, i_ex_illegal, i_ex_ebreak,
               i_ex_ecall, i_ex_ld_addr, i_ex_st_addr, i_mret, i_msip, i_mtip, i_meip,
               i_mstatus_mie, i_mie, i_mtvec, i_mepc, i_mem_busy,
        output o_stall, o_flush, o_trap_we, o_mret_restore, o_redirect, o_drain_err,
               o_epc, o_cause, o_tval, o_target
    );
endinterface

// File: rtl/csr_trap_ctrl_prio_enc.sv
// trap_prio_enc: picks the highest-priority exception, else the highest eligible interrupt.
module trap_prio_enc
    import csr_trap_ctrl_pkg::*;
#(
    parameter int XLEN = DEF_XLEN
) (
    input  logic            ex_inst_addr, ex_illegal, ex_ebreak, ex_ecall, ex_ld_addr, ex_st_addr,
    input  logic            msip, mtip, meip, mstatus_mie,
    input  logic [2:0]      mie,
    output logic            take,
    output logic            is_irq,
    output logic [XLEN-1:0] cause,
    output tval_sel_e       tval_sel
);
    logic [2:0]         irq;
    logic               exc;
    logic [CAUSE_W-1:0] code;
    always_comb begin
        irq    = {meip, mtip, msip} & mie & {3{mstatus_mie}};
        exc    = ex_inst_addr | ex_illegal | ex_ebreak | ex_ecall | ex_ld_addr | ex_st_addr;
        take   = exc | (|irq);
        is_irq = ~exc & (|irq);
        code   = ex_inst_addr ? CAUSE_INST_MISALIGN :
                 ex_illegal   ? CAUSE_ILLEGAL       :
                 ex_ebreak    ? CAUSE_BREAKPOINT    :
                 ex_ecall     ? CAUSE_ECALL_M       :
                 ex_ld_addr   ? CAUSE_LD_MISALIGN   :
                 ex_st_addr   ? CAUSE_ST_MISALIGN   :
                 irq[2]       ? CAUSE_MEI           :
                 irq[0]       ? CAUSE_MSI           : CAUSE_MTI;
        cause  = {is_irq, (XLEN-1)'(code)};
        tval_sel = !exc                     ? TV_ZERO :
                   ex_inst_addr             ? TV_ADDR :
                   ex_illegal               ? TV_INST :
                   (ex_ebreak | ex_ecall)   ? TV_ZERO : TV_ADDR;
    end
endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: M-mode trap entry (flush, drain, commit, redirect) and MRET sequencer.
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int DRAIN_MAX = 15
) (
    input logic             i_clk,
    input logic             i_rst,
    csr_trap_ctrl_if.slave  bus
);
    localparam int CW = $clog2(DRAIN_MAX + 1);
    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   epc_q, epc_d, cause_q, cause_d, tval_q, tval_d, base;
    logic              irq_q, irq_d, mret_q, mret_d, err_q, err_d;
    logic              take, is_irq, exc, acc_trap, acc_mret;
    logic [XLEN-1:0]   cause;
    tval_sel_e         tval_sel;
    trap_prio_enc #(.XLEN(XLEN)) u_prio_enc (
        .ex_inst_addr (bus.i_ex_inst_addr),
        .ex_illegal   (bus.i_ex_illegal),
        .ex_ebreak    (bus.i_ex_ebreak),
        .ex_ecall     (bus.i_ex_ecall),
        .ex_ld_addr   (bus.i_ex_ld_addr),
        .ex_st_addr   (bus.i_ex_st_addr),
        .msip         (bus.i_msip),
        .mtip         (bus.i_mtip),
        .meip         (bus.i_meip),
        .mstatus_mie  (bus.i_mstatus_mie),
        .mie          (bus.i_mie),
        .take         (take),
        .is_irq       (is_irq),
        .cause        (cause),
        .tval_sel     (tval_sel)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        tval_d  = tval_q;
        irq_d   = irq_q;
        mret_d  = mret_q;
        err_d   = err_q;
        bus.o_stall        = 1'b0;
        bus.o_flush        = 1'b0;
        bus.o_trap_we      = 1'b0;
        bus.o_mret_restore = 1'b0;
        bus.o_redirect     = 1'b0;
        bus.o_target       = '0;
        exc      = take & ~is_irq;
        acc_trap = bus.i_valid & take & (exc | ~bus.i_mret);
        acc_mret = bus.i_valid & bus.i_mret & ~exc;
        base     = bus.i_mtvec & ~XLEN'(3);
        case (state_q)
            S_IDLE: begin
                if (acc_trap) begin
                    epc_d   = bus.i_PC;
                    cause_d = cause;
                    tval_d  = tval_sel == TV_INST ? XLEN'(bus.i_inst) :
                              tval_sel == TV_ADDR ? bus.i_badaddr : '0;
                    irq_d   = is_irq;
                    mret_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = bus.i_mem_busy ? S_DRAIN : S_COMMIT;
                    bus.o_stall = 1'b1;
                    bus.o_flush = 1'b1;
                end else if (acc_mret) begin
                    mret_d  = 1'b1;
                    state_d = S_REDIRECT;
                    bus.o_stall        = 1'b1;
                    bus.o_flush        = 1'b1;
                    bus.o_mret_restore = 1'b1;
                end
            end
            S_DRAIN: begin
                bus.o_stall = 1'b1;
                // a memory op that never finishes must not wedge the trap; commit anyway and flag it
                if (!bus.i_mem_busy) state_d = S_COMMIT;
                else if (cnt_q == CW'(DRAIN_MAX - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_COMMIT;
                end else cnt_d = cnt_q + 1'b1;
            end
            S_COMMIT: begin
                bus.o_stall   = 1'b1;
                bus.o_trap_we = 1'b1;
                state_d       = S_REDIRECT;
            end
            default: begin
                bus.o_stall    = 1'b1;
                bus.o_redirect = 1'b1;
                bus.o_target   = mret_q ? bus.i_mepc :
                                 (irq_q & bus.i_mtvec[0]) ? base + {cause_q[XLEN-3:0], 2'b00} : base;
                state_d        = S_IDLE;
            end
        endcase
        bus.o_epc       = epc_q;
        bus.o_cause     = cause_q;
        bus.o_tval      = tval_q;
        bus.o_drain_err = err_q;
        if (!i_rst) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            epc_d   = '0;
            cause_d = '0;
            tval_d  = '0;
            irq_d   = 1'b0;
            mret_d  = 1'b0;
            err_d   = 1'b0;
            bus.o_stall        = 1'b0;
            bus.o_flush        = 1'b0;
            bus.o_trap_we      = 1'b0;
            bus.o_mret_restore = 1'b0;
            bus.o_redirect     = 1'b0;
            bus.o_target       = '0;
            bus.o_epc          = '0;
            bus.o_cause        = '0;
            bus.o_tval         = '0;
            bus.o_drain_err    = 1'b0;
        end
    end
    always_ff @(posedge i_clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        epc_q   <= epc_d;
        cause_q <= cause_d;
        tval_q  <= tval_d;
        irq_q   <= irq_d;
        mret_q  <= mret_d;
        err_q   <= err_d;
    end
endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Machine-mode trap sequencer placed between the core pipeline and the CSR unit. It collects synchronous exception flags and the three M-mode interrupt lines and prioritises them. It then runs a multi-cycle trap entry: flush, drain any in-flight memory access, commit mepc/mcause/mtval/mstatus, and redirect the PC. It also sequences MRET returns.

## Interface
Parameters:
- XLEN, `XLEN from defines.vh: datapath width.
- DRAIN_MAX, 15: maximum number of DRAIN cycles before a forced commit.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-low.
- i_valid  in  1  instruction at the commit boundary is valid this cycle.
- i_PC, i_inst, i_badaddr  in  XLEN/32/XLEN  PC, encoding and faulting address of the boundary instruction.
- i_ex_inst_addr, i_ex_illegal, i_ex_ebreak, i_ex_ecall, i_ex_ld_addr, i_ex_st_addr  in  1 each  exception flags.
- i_mret  in  1  MRET at the boundary.
- i_msip, i_mtip, i_meip  in  1 each  pending software, timer and external interrupts (level).
- i_mstatus_mie  in  1  global interrupt enable.
- i_mie  in  3  per-source enables {MEIE, MTIE, MSIE}.
- i_mtvec, i_mepc  in  XLEN  current CSR values.
- i_mem_busy  in  1  a load or store is still in flight.
- o_stall, o_flush  out  1  hold the fetch stage; kill younger instructions.
- o_trap_we  out  1  one-cycle strobe. The CSR unit loads mepc/mcause/mtval and sets mpie<=mie, mie<=0.
- o_epc, o_cause, o_tval  out  XLEN  values written on o_trap_we.
- o_mret_restore  out  1  one-cycle strobe. The CSR unit sets mie<=mpie, mpie<=1.
- o_redirect  out  1  PC load strobe. o_target  out  XLEN  new PC.
- o_drain_err  out  1  sticky flag: DRAIN timed out.

## Operation
States: IDLE, DRAIN, COMMIT, REDIRECT.
- Exception priority, high to low:
  - inst misaligned: cause 0
  - illegal: cause 2; tval = i_inst
  - ebreak: cause 3
  - ecall: cause 11
  - load misaligned: cause 4
  - store misaligned: cause 6
- tval for the misaligned exceptions = i_badaddr. tval = 0 for ecall, ebreak and all interrupts.
- Interrupt eligibility: i_pX & i_mie bit & i_mstatus_mie.
- Interrupt priority: MEI (cause 11) > MSI (3) > MTI (7). Interrupt causes have bit XLEN-1 set.
- A synchronous exception beats an interrupt in the same cycle. The interrupt remains pending.
- The MRET check follows exceptions and precedes interrupts.
- IDLE, i_valid and a trap selected:
  - Latch epc = i_PC, cause and tval.
  - Pulse o_flush. Raise o_stall.
  - Go to DRAIN if i_mem_busy is high, else COMMIT.
- DRAIN:
  - Count cycles. On !i_mem_busy go to COMMIT.
  - When the count reaches DRAIN_MAX, set o_drain_err and go to COMMIT.
- COMMIT: o_trap_we = 1 with the latched values, then go to REDIRECT.
- REDIRECT: o_redirect = 1, then go to IDLE.
  - Target = {i_mtvec[XLEN-1:2], 2'b00}.
  - If i_mtvec[0] = 1 and the trap is an interrupt, target = base + 4*cause[XLEN-2:0].
- IDLE, i_valid and i_mret with no exception:
  - Pulse o_flush and o_mret_restore.
  - Go to REDIRECT with target i_mepc.
- Outside IDLE, all exception, interrupt and MRET inputs are ignored.
- o_stall is high in DRAIN, COMMIT and REDIRECT, and in the IDLE cycle where a trap or MRET is accepted.

## Timing
- Reset (any state, including mid-sequence):
  - Next state is IDLE. The drain counter and latched epc/cause/tval are cleared.
  - o_drain_err is cleared.
  - All outputs are 0: o_stall, o_flush, o_trap_we, o_mret_restore, o_redirect, o_epc, o_cause, o_tval, o_target.
- Trap with no drain:
  - Accept in cycle T.
  - o_trap_we in T+1. o_redirect in T+2.
  - A new acceptance is possible at T+3.
- Trap with drain of N busy cycles: o_trap_we in T+1+N, capped at T+1+DRAIN_MAX.
- MRET: accept in T, o_mret_restore in T, o_redirect in T+1.
- o_epc/o_cause/o_tval are held stable from COMMIT through REDIRECT.
- i_mtvec is sampled in REDIRECT, so the post-commit value is used.

## Structure
- Add to csr_defines.vh:
  - Cause codes (CAUSE_INST_MISALIGN, CAUSE_ILLEGAL, CAUSE_BREAKPOINT, CAUSE_ECALL_M, CAUSE_LD_MISALIGN, CAUSE_ST_MISALIGN, CAUSE_MSI, CAUSE_MTI, CAUSE_MEI).
  - The interrupt bit position.
  - State encodings.
- One sub-module, trap_prio_enc: a combinational priority encoder. It outputs {take, is_irq, cause, tval_sel}. The FSM lives in csr_trap_ctrl.

## Test plan
- Illegal, i_inst=32'hFFFFFFFF, i_PC=32'h100, mem idle -> o_trap_we at T+1 with cause 2, tval FFFFFFFF, epc 100; o_redirect at T+2 to mtvec base.
- Load misaligned plus i_meip, all enables set -> cause 4 taken first; the interrupt is taken at the next valid boundary with cause 32'h8000000B.
- i_mtip, MIE=1, mtvec=32'h201 -> cause 32'h80000007; target 32'h21C (vectored); tval 0.
- ecall with i_mem_busy high for 3 cycles -> o_trap_we at T+4. Busy held for 20 cycles -> commit at T+16 and o_drain_err = 1.
- MRET, i_mepc=32'h400 -> o_mret_restore at T, o_redirect to 400 at T+1.
- Reset asserted in DRAIN -> all outputs 0 next cycle, state IDLE, no o_trap_we.
